// File: rtl/single_port_mem_scheduler.sv
// Round-robin scheduler sharing one single-port memory between load and store requesters.
// Loads return data through per-port EMPTY/PENDING/FULL slots; stores are counted against basic-block announcements.
module single_port_mem_scheduler #(
    parameter int LOAD_COUNT   = 2,
    parameter int STORE_COUNT  = 2,
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int BB_COUNT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LOAD_COUNT-1:0]                 rd_valid,
    output logic [LOAD_COUNT-1:0]                 rd_ready,
    input  logic [LOAD_COUNT*ADDRESS_SIZE-1:0]    rd_addr,
    output logic [LOAD_COUNT-1:0]                 rd_data_valid,
    input  logic [LOAD_COUNT-1:0]                 rd_data_ready,
    output logic [LOAD_COUNT*DATA_SIZE-1:0]       rd_data,
    input  logic [STORE_COUNT-1:0]                wr_valid,
    output logic [STORE_COUNT-1:0]                wr_ready,
    input  logic [STORE_COUNT*ADDRESS_SIZE-1:0]   wr_addr,
    input  logic [STORE_COUNT*DATA_SIZE-1:0]      wr_data,
    output logic                                  mem_en,
    output logic                                  mem_we,
    output logic [ADDRESS_SIZE-1:0]               mem_addr,
    output logic [DATA_SIZE-1:0]                  mem_wdata,
    input  logic [DATA_SIZE-1:0]                  mem_rdata,
    input  logic [BB_COUNT-1:0]                   bb_valid,
    input  logic [BB_COUNT*32-1:0]                bb_st_count,
    output logic                                  empty_valid,
    output logic                                  err_underflow
);

    localparam int N     = LOAD_COUNT + STORE_COUNT;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_FULL} slot_t;

    slot_t                 r_slot      [LOAD_COUNT];
    slot_t                 w_slot_nxt  [LOAD_COUNT];
    logic [DATA_SIZE-1:0]  r_slot_data [LOAD_COUNT];
    logic [PTR_W-1:0]      r_ptr;
    logic [31:0]           r_st_cnt;
    logic                  r_err;

    logic [N-1:0]          w_elig;
    logic [N-1:0]          w_grant;
    logic                  w_any;
    logic [PTR_W-1:0]      w_gidx;
    logic                  w_st_grant;
    logic [31:0]           w_bb_sum;
    logic [31:0]           w_cnt_sum;

    always_comb begin
        for (int i = 0; i < LOAD_COUNT; i++) begin
            w_elig[i] = rd_valid[i] &&
                        ((r_slot[i] == SLOT_EMPTY) || ((r_slot[i] == SLOT_FULL) && rd_data_ready[i]));
        end
        for (int j = 0; j < STORE_COUNT; j++) begin
            w_elig[LOAD_COUNT+j] = wr_valid[j];
        end
    end

    // Circular search: indices at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_any && (i >= int'(r_ptr)) && w_elig[i]) begin
                w_any  = 1'b1;
                w_gidx = PTR_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_any && (i < int'(r_ptr)) && w_elig[i]) begin
                w_any  = 1'b1;
                w_gidx = PTR_W'(i);
            end
        end
        w_any = w_any && rst;
        for (int i = 0; i < N; i++) begin
            w_grant[i] = w_any && (w_gidx == PTR_W'(i));
        end
    end

    assign rd_ready   = w_grant[LOAD_COUNT-1:0];
    assign wr_ready   = w_grant[N-1:LOAD_COUNT];
    assign w_st_grant = |wr_ready;

    always_comb begin
        mem_en    = w_any;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < LOAD_COUNT; i++) begin
            if (w_grant[i]) mem_addr = rd_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
        for (int j = 0; j < STORE_COUNT; j++) begin
            if (w_grant[LOAD_COUNT+j]) begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr[j*ADDRESS_SIZE +: ADDRESS_SIZE];
                mem_wdata = wr_data[j*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LOAD_COUNT; i++) begin
            w_slot_nxt[i] = r_slot[i];
            case (r_slot[i])
                SLOT_EMPTY:   if (w_grant[i]) w_slot_nxt[i] = SLOT_PENDING;
                SLOT_PENDING: w_slot_nxt[i] = SLOT_FULL;
                SLOT_FULL: begin
                    if (w_grant[i])            w_slot_nxt[i] = SLOT_PENDING;
                    else if (rd_data_ready[i]) w_slot_nxt[i] = SLOT_EMPTY;
                end
                default:      w_slot_nxt[i] = SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LOAD_COUNT; i++) begin
                r_slot[i]      <= SLOT_EMPTY;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOAD_COUNT; i++) begin
                r_slot[i] <= w_slot_nxt[i];
                if (r_slot[i] == SLOT_PENDING) r_slot_data[i] <= mem_rdata;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LOAD_COUNT; i++) begin
            rd_data_valid[i]                     = (r_slot[i] == SLOT_FULL);
            rd_data[i*DATA_SIZE +: DATA_SIZE]    = r_slot_data[i];
        end
    end

    always_comb begin
        w_bb_sum = '0;
        for (int k = 0; k < BB_COUNT; k++) begin
            if (bb_valid[k]) w_bb_sum = w_bb_sum + bb_st_count[k*32 +: 32];
        end
        w_cnt_sum = r_st_cnt + w_bb_sum;
    end

    // A store that would take the count below zero pins it at zero and flags the error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_st_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_any) r_ptr <= (w_gidx == PTR_W'(N-1)) ? '0 : w_gidx + 1'b1;
            if (w_st_grant) begin
                if (w_cnt_sum == 32'd0) begin
                    r_st_cnt <= 32'd0;
                    r_err    <= 1'b1;
                end else begin
                    r_st_cnt <= w_cnt_sum - 32'd1;
                end
            end else begin
                r_st_cnt <= w_cnt_sum;
            end
        end
    end

    assign empty_valid   = (r_st_cnt == 32'd0) && !(|bb_valid);
    assign err_underflow = r_err;

endmodule

// File: tb/tb_single_port_mem_scheduler.sv
// Bench for single_port_mem_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model of the scheduling rules.
module tb_single_port_mem_scheduler;

    localparam int L  = 2;
    localparam int S  = 2;
    localparam int N  = L + S;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BB = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [L-1:0]      rd_valid, rd_ready, rd_data_valid, rd_data_ready;
    logic [L*AW-1:0]   rd_addr;
    logic [L*DW-1:0]   rd_data;
    logic [S-1:0]      wr_valid, wr_ready;
    logic [S*AW-1:0]   wr_addr;
    logic [S*DW-1:0]   wr_data;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic [BB-1:0]     bb_valid;
    logic [BB*32-1:0]  bb_st_count;
    logic              empty_valid, err_underflow;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    single_port_mem_scheduler #(
        .LOAD_COUNT(L), .STORE_COUNT(S), .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .BB_COUNT(BB)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .bb_valid(bb_valid), .bb_st_count(bb_st_count),
        .empty_valid(empty_valid), .err_underflow(err_underflow)
    );

    typedef struct {
        logic [1:0]  rv, rdr, wv;
        logic        bbv;
        logic [31:0] bbc, rdat;
        logic [1:0]  e_rr, e_wr;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_dv;
        logic [31:0] e_d0;
        logic        e_empty, e_err;
    } vec_t;

    vec_t tbl [10];

    // behavioural model state: slot 0=empty 1=waiting for memory 2=holding data
    int          m_ptr;
    int          m_st  [L];
    logic [31:0] m_dat [L];
    longint      m_cnt;
    bit          m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid = '0; rd_data_ready = '1; wr_valid = '0;
        bb_valid = '0; bb_st_count = '0; mem_rdata = '0;
        rd_addr = {32'h20, 32'h10};
        wr_addr = {32'h200, 32'h100};
        wr_data = {32'hD1, 32'hD0};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        for (int i = 0; i < L; i++) begin m_st[i] = 0; m_dat[i] = '0; end
    endtask

    function automatic bit elig(input int idx);
        if (idx < L) return rd_valid[idx] && (m_st[idx] == 0 || (m_st[idx] == 2 && rd_data_ready[idx]));
        return wr_valid[idx-L];
    endfunction

    initial begin
        int g;
        logic [1:0]  e_rr, e_wr;
        logic [31:0] e_addr, e_wdata;
        longint      tmp;

        tbl[0] = '{2'b01, 2'b11, 2'b00, 1'b0, 32'd0, 32'h00, 2'b01, 2'b00, 1'b1, 1'b0, 32'h010, 32'h00, 2'b00, 32'h00, 1'b1, 1'b0};
        tbl[1] = '{2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 32'hAB, 2'b00, 2'b00, 1'b0, 1'b0, 32'h000, 32'h00, 2'b00, 32'h00, 1'b1, 1'b0};
        tbl[2] = '{2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h000, 32'h00, 2'b01, 32'hAB, 1'b1, 1'b0};
        tbl[3] = '{2'b00, 2'b11, 2'b00, 1'b1, 32'd3, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h000, 32'h00, 2'b00, 32'h00, 1'b0, 1'b0};
        tbl[4] = '{2'b00, 2'b11, 2'b01, 1'b0, 32'd0, 32'h00, 2'b00, 2'b01, 1'b1, 1'b1, 32'h100, 32'hD0, 2'b00, 32'h00, 1'b0, 1'b0};
        tbl[5] = '{2'b00, 2'b11, 2'b11, 1'b0, 32'd0, 32'h00, 2'b00, 2'b10, 1'b1, 1'b1, 32'h200, 32'hD1, 2'b00, 32'h00, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 2'b11, 2'b01, 1'b0, 32'd0, 32'h00, 2'b00, 2'b01, 1'b1, 1'b1, 32'h100, 32'hD0, 2'b00, 32'h00, 1'b0, 1'b0};
        tbl[7] = '{2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h000, 32'h00, 2'b00, 32'h00, 1'b1, 1'b0};
        tbl[8] = '{2'b00, 2'b11, 2'b10, 1'b0, 32'd0, 32'h00, 2'b00, 2'b10, 1'b1, 1'b1, 32'h200, 32'hD1, 2'b00, 32'h00, 1'b1, 1'b0};
        tbl[9] = '{2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 32'h00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h000, 32'h00, 2'b00, 32'h00, 1'b1, 1'b1};

        idle_inputs();
        rst = 1'b0;
        #3;
        chk("reset_dv",    64'(rd_data_valid), 64'd0);
        chk("reset_rdata", 64'(rd_data), 64'd0);
        chk("reset_en",    64'(mem_en), 64'd0);
        chk("reset_err",   64'(err_underflow), 64'd0);
        do_reset();

        // directed table: single load latency, store counting, underflow
        for (int r = 0; r < 10; r++) begin
            rd_valid = tbl[r].rv; rd_data_ready = tbl[r].rdr; wr_valid = tbl[r].wv;
            bb_valid = tbl[r].bbv; bb_st_count = tbl[r].bbc; mem_rdata = tbl[r].rdat;
            #3;
            chk($sformatf("tbl%0d_rd_ready", r), 64'(rd_ready), 64'(tbl[r].e_rr));
            chk($sformatf("tbl%0d_wr_ready", r), 64'(wr_ready), 64'(tbl[r].e_wr));
            chk($sformatf("tbl%0d_mem_en", r),   64'(mem_en), 64'(tbl[r].e_en));
            chk($sformatf("tbl%0d_mem_we", r),   64'(mem_we), 64'(tbl[r].e_we));
            chk($sformatf("tbl%0d_mem_addr", r), 64'(mem_addr), 64'(tbl[r].e_addr));
            chk($sformatf("tbl%0d_mem_wdata", r), 64'(mem_wdata), 64'(tbl[r].e_wdata));
            chk($sformatf("tbl%0d_dv", r),       64'(rd_data_valid), 64'(tbl[r].e_dv));
            if (tbl[r].e_dv[0]) chk($sformatf("tbl%0d_rd_data0", r), 64'(rd_data[31:0]), 64'(tbl[r].e_d0));
            chk($sformatf("tbl%0d_empty", r),    64'(empty_valid), 64'(tbl[r].e_empty));
            chk($sformatf("tbl%0d_err", r),      64'(err_underflow), 64'(tbl[r].e_err));
            tick();
        end

        // all requesters busy: strict rotation 0,1,2,3,...
        do_reset();
        rd_valid = 2'b11; wr_valid = 2'b11; rd_data_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #3;
            chk($sformatf("rr_cycle%0d", c), 64'({wr_ready, rd_ready}), 64'(4'b0001 << (c % N)));
            tick();
        end

        // port 0 full and stalled: never re-granted, data held
        do_reset();
        rd_valid = 2'b01; rd_data_ready = 2'b00;
        #3;
        chk("stall_grant0", 64'(rd_ready), 64'(2'b01));
        tick();
        rd_valid = 2'b00; mem_rdata = 32'h5A;
        tick();
        mem_rdata = 32'h0;
        rd_valid = 2'b11; wr_valid = 2'b11; rd_data_ready = 2'b10;
        for (int c = 0; c < 8; c++) begin
            #3;
            chk("stall_no_port0", 64'(rd_ready[0]), 64'd0);
            chk("stall_served",   64'(mem_en), 64'd1);
            chk("stall_hold",     64'(rd_data[31:0]), 64'h5A);
            chk("stall_dv0",      64'(rd_data_valid[0]), 64'd1);
            tick();
        end

        // reset while a load is pending discards it; search restarts at 0
        do_reset();
        rd_valid = 2'b10; rd_data_ready = 2'b11;
        #3;
        chk("rstmid_grant1", 64'(rd_ready), 64'(2'b10));
        tick();
        rd_valid = 2'b11; wr_valid = 2'b11; mem_rdata = 32'h77;
        rst = 1'b0;
        #2;
        chk("rstmid_en",   64'(mem_en), 64'd0);
        chk("rstmid_we",   64'(mem_we), 64'd0);
        chk("rstmid_ack",  64'({wr_ready, rd_ready}), 64'd0);
        tick();
        tick();
        rst = 1'b1; rd_valid = 2'b00; wr_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("rstmid_dv", 64'(rd_data_valid), 64'd0);
            tick();
        end
        rd_valid = 2'b11; wr_valid = 2'b11;
        #3;
        chk("rstmid_first", 64'({wr_ready, rd_ready}), 64'(4'b0001));
        tick();

        // randomized traffic against the behavioural model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rd_valid      = 2'($urandom);
            rd_data_ready = 2'($urandom);
            wr_valid      = 2'($urandom);
            bb_valid      = 1'($urandom_range(0, 3) == 0);
            bb_st_count   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
            rd_addr       = {$urandom, $urandom};
            wr_addr       = {$urandom, $urandom};
            wr_data       = {$urandom, $urandom};
            mem_rdata     = $urandom;
            #3;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && elig((m_ptr + k) % N)) g = (m_ptr + k) % N;
            end
            e_rr = '0; e_wr = '0; e_addr = '0; e_wdata = '0;
            if (g >= 0 && g < L) begin
                e_rr[g] = 1'b1;
                e_addr  = rd_addr[g*AW +: AW];
            end else if (g >= L) begin
                e_wr[g-L] = 1'b1;
                e_addr    = wr_addr[(g-L)*AW +: AW];
                e_wdata   = wr_data[(g-L)*DW +: DW];
            end
            chk("rnd_rd_ready",  64'(rd_ready), 64'(e_rr));
            chk("rnd_wr_ready",  64'(wr_ready), 64'(e_wr));
            chk("rnd_mem_en",    64'(mem_en), 64'(g >= 0));
            chk("rnd_mem_we",    64'(mem_we), 64'(g >= L));
            chk("rnd_mem_addr",  64'(mem_addr), 64'(e_addr));
            chk("rnd_mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            for (int i = 0; i < L; i++) begin
                chk("rnd_dv", 64'(rd_data_valid[i]), 64'(m_st[i] == 2));
                if (m_st[i] == 2) chk("rnd_rd_data", 64'(rd_data[i*DW +: DW]), 64'(m_dat[i]));
            end
            chk("rnd_empty", 64'(empty_valid), 64'(m_cnt == 0 && bb_valid == 1'b0));
            chk("rnd_err",   64'(err_underflow), 64'(m_err));
            for (int i = 0; i < L; i++) begin
                if (m_st[i] == 1) begin
                    m_dat[i] = mem_rdata;
                    m_st[i]  = 2;
                end else if (g == i) begin
                    m_st[i] = 1;
                end else if (m_st[i] == 2 && rd_data_ready[i]) begin
                    m_st[i] = 0;
                end
            end
            tmp = (m_cnt + (bb_valid[0] ? longint'(bb_st_count) : 64'sd0)) & 64'hFFFF_FFFF;
            if (g >= L) begin
                if (tmp - 1 < 0) begin
                    m_cnt = 0;
                    m_err = 1'b1;
                end else begin
                    m_cnt = tmp - 1;
                end
            end else begin
                m_cnt = tmp;
            end
            if (g >= 0) m_ptr = (g + 1) % N;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
